// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming 3-to-8 decoder and its bench.
package decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_DRIVE
  } state_e;

  function automatic logic [OUT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo_code.sv
// Small synchronous FIFO for decoder codes; DEPTH must be a power of two >= 2.
module sync_fifo_code
  import decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/decoder_3to8_seq.sv
// Streaming 3-to-8 decoder: queued codes drive one-hot strobes for hold_len cycles each.
module decoder_3to8_seq
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              en,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [OUT_W-1:0]  out_onehot,
  output logic              out_valid,
  output logic              busy
);

  state_e              state_q;
  logic [HOLD_W-1:0]   cnt_q;
  logic [HOLD_W-1:0]   hold_eff;
  logic [CODE_W-1:0]   head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                last_cycle;
  logic                load;

  sync_fifo_code #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_code),
    .pop   (load),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    hold_eff   = (hold_len == '0) ? HOLD_W'(1) : hold_len;
    last_cycle = (cnt_q == HOLD_W'(1));
    // Pop in IDLE, or on the final DRIVE cycle so the next code follows with no gap.
    load       = en && !fifo_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_DRIVE) && last_cycle));
    in_ready   = !fifo_full;
    out_valid  = |out_onehot;
    busy       = !fifo_empty || (state_q == ST_DRIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_onehot <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q    <= ST_DRIVE;
            cnt_q      <= hold_eff;
            out_onehot <= onehot_of(head);
          end
        end
        ST_DRIVE: begin
          // With en low, counter and output simply hold.
          if (en) begin
            if (last_cycle) begin
              if (load) begin
                cnt_q      <= hold_eff;
                out_onehot <= onehot_of(head);
              end else begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                out_onehot <= '0;
              end
            end else begin
              cnt_q <= cnt_q - HOLD_W'(1);
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          out_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed self-checking bench for decoder_3to8_seq.
module tb_decoder_3to8_seq;
  import decoder_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              en;
  logic [3:0]        hold_len;
  logic [OUT_W-1:0]  out_onehot;
  logic              out_valid;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  decoder_3to8_seq #(
    .HOLD_W (4),
    .DEPTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .en         (en),
    .hold_len   (hold_len),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_onehot"}, out_onehot, 8'h00);
    chk({tag, "_valid"}, 8'(out_valid), 8'h00);
    chk({tag, "_ready"}, 8'(in_ready), 8'h01);
    chk({tag, "_busy"}, 8'(busy), 8'h00);
  endtask

  logic [7:0] cap[$];
  int         first_k;
  int         last_k;
  int         seen;
  bit         saw_bp;

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    en       = 1'b0;
    hold_len = 4'd0;
    #1 rst = 1'b1;
    #1 chk_idle_reset("por");
    tick();
    tick();
    rst = 1'b0;

    // 1: reset pulse while a code is being driven
    en = 1'b1; hold_len = 4'd3;
    in_valid = 1'b1; in_code = 3'd7;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t1_drive", out_onehot, 8'h80);
    #2 rst = 1'b1;
    #1 chk_idle_reset("t1_rst");
    tick();
    rst = 1'b0;
    tick();
    chk("t1_after", out_onehot, 8'h00);

    // 2: walk all codes with hold 2 and backpressure
    hold_len = 4'd2;
    cap.delete();
    first_k = -1; last_k = -1; saw_bp = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int guard;
          in_valid = 1'b1;
          in_code  = 3'(i);
          guard    = 0;
          while (!in_ready && guard < 50) begin
            saw_bp = 1'b1;
            guard++;
            tick();
          end
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          tick();
          if (out_valid) begin
            cap.push_back(out_onehot);
            if (first_k < 0) first_k = k;
            last_k = k;
          end
        end
      end
    join
    chk("t2_count", 8'(cap.size()), 8'd16);
    for (int j = 0; j < 16 && j < cap.size(); j++) begin
      logic [7:0] e;
      e = 8'h01 << (j / 2);
      chk($sformatf("t2_seq%0d", j), cap[j], e);
    end
    chk("t2_nogap", 8'(last_k - first_k + 1), 8'd16);
    chk("t2_backpressure", 8'(saw_bp), 8'h01);
    chk("t2_idle_onehot", out_onehot, 8'h00);
    chk("t2_idle_busy", 8'(busy), 8'h00);

    // 3: hold_len 0 behaves as 1
    hold_len = 4'd0;
    in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("t3_lat", out_onehot, 8'h00);
    tick();
    chk("t3_on", out_onehot, 8'h20);
    tick();
    chk("t3_off", out_onehot, 8'h00);
    chk("t3_busy", 8'(busy), 8'h00);

    // 4: fill FIFO while paused, then release
    en = 1'b0; hold_len = 4'd1;
    in_valid = 1'b1; in_code = 3'd3;
    tick();
    chk("t4_ready1", 8'(in_ready), 8'h01);
    in_code = 3'd6;
    tick();
    chk("t4_full", 8'(in_ready), 8'h00);
    in_code = 3'd1;
    tick();
    chk("t4_blocked", 8'(in_ready), 8'h00);
    chk("t4_paused", out_onehot, 8'h00);
    en = 1'b1;
    tick();
    chk("t4_out3", out_onehot, 8'h08);
    chk("t4_space", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    chk("t4_out6", out_onehot, 8'h40);
    tick();
    chk("t4_out1", out_onehot, 8'h02);
    tick();
    chk("t4_done", out_onehot, 8'h00);
    tick();
    chk("t4_nodup", out_onehot, 8'h00);
    chk("t4_busy", 8'(busy), 8'h00);

    // 5: pause in the middle of a hold
    hold_len = 4'd4;
    in_valid = 1'b1; in_code = 3'd2;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_onehot == 8'h04) seen++;
      else if (out_onehot != 8'h00) chk("t5_stray", out_onehot, 8'h04);
      if (k == 1) en = 1'b0;
      if (k == 4) en = 1'b1;
    end
    chk("t5_cycles", 8'(seen), 8'd7);

    // 6: reset mid-drive with two queued codes
    hold_len = 4'd8;
    in_valid = 1'b1; in_code = 3'd4;
    tick();
    in_code = 3'd1;
    tick();
    in_code = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("t6_drive", out_onehot, 8'h10);
    chk("t6_full", 8'(in_ready), 8'h00);
    #2 rst = 1'b1;
    #1 chk_idle_reset("t6_rst");
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t6_nostale", 8'(seen), 8'd0);
    chk("t6_busy", 8'(busy), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
